// File: rtl/fp_add_normalize.sv
// Normalizes a raw mantissa sum/difference and its provisional exponent into {0, exp, frac}.
// Latency: 1 cycle after capture for carry/normal/zero/special; 1+k+1 for k left shifts (max 25).
// Backpressure: single operation in flight; in_ready only in IDLE, result held in DONE until out_ready.
module fp_add_normalize #(
    parameter int EXP_W  = 8,
    parameter int FRAC_W = 23
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [EXP_W-1:0]        in_exp,
    input  logic [FRAC_W+1:0]       in_mant,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [EXP_W+FRAC_W:0]   temp_floating_point_out,
    output logic                    overflow,
    output logic                    underflow
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    localparam logic [EXP_W-1:0] EXP_ALL1 = {EXP_W{1'b1}};
    localparam logic [EXP_W-1:0] EXP_ONE  = EXP_W'(1);

    // Bit positions inside the mantissa word: carry above hidden above fraction.
    localparam int CARRY_BIT  = FRAC_W + 1;
    localparam int HIDDEN_BIT = FRAC_W;

    state_t                 state_q, state_d;
    logic [EXP_W-1:0]       exp_q,   exp_d;
    logic [FRAC_W+1:0]      mant_q,  mant_d;
    logic                   ovf_q,   ovf_d;
    logic                   unf_q,   unf_d;

    // Exponent after a carry right-shift; only used when in_exp is not all-ones,
    // so the increment cannot wrap.
    logic [EXP_W-1:0]       exp_inc;
    // Operand classification at capture time.
    logic                   in_special;
    logic                   in_zero;
    logic                   in_carry;
    logic                   in_normal;

    // Classify the incoming operand.
    always_comb begin
        exp_inc    = in_exp + EXP_ONE;
        in_special = (in_exp == EXP_ALL1);
        in_zero    = (in_mant == '0);
        in_carry   = in_mant[CARRY_BIT];
        in_normal  = (in_mant[CARRY_BIT:HIDDEN_BIT] == 2'b01);
    end

    // Next-state and datapath update for the normalization FSM.
    always_comb begin
        state_d = state_q;
        exp_d   = exp_q;
        mant_d  = mant_q;
        ovf_d   = ovf_q;
        unf_d   = unf_q;

        case (state_q)
            S_IDLE: begin
                if (in_valid) begin
                    ovf_d = 1'b0;
                    unf_d = 1'b0;
                    if (in_special) begin
                        // NaN / infinity pass straight through untouched.
                        exp_d   = in_exp;
                        mant_d  = in_mant;
                        state_d = S_DONE;
                    end else if (in_zero) begin
                        // Exact cancellation gives a clean zero, not an underflow.
                        exp_d   = '0;
                        mant_d  = '0;
                        state_d = S_DONE;
                    end else if (in_carry) begin
                        // Single right shift; the dropped LSB is the truncation.
                        mant_d  = in_mant >> 1;
                        exp_d   = exp_inc;
                        if (exp_inc == EXP_ALL1) begin
                            // Exponent hit the reserved value: saturate to infinity.
                            mant_d[FRAC_W-1:0] = '0;
                            ovf_d              = 1'b1;
                        end
                        state_d = S_DONE;
                    end else if (in_normal) begin
                        exp_d   = in_exp;
                        mant_d  = in_mant;
                        state_d = S_DONE;
                    end else begin
                        // Leading zeros: shift left one bit per cycle. An exponent of 0
                        // (denormal operand) carries the same scale as exponent 1.
                        mant_d  = in_mant;
                        exp_d   = (in_exp == '0) ? EXP_ONE : in_exp;
                        state_d = S_SHIFT;
                    end
                end
            end

            S_SHIFT: begin
                if (mant_q[HIDDEN_BIT]) begin
                    state_d = S_DONE;
                end else if (exp_q > EXP_ONE) begin
                    mant_d = mant_q << 1;
                    exp_d  = exp_q - EXP_ONE;
                end else begin
                    // Out of exponent range: leave the mantissa as a denormal.
                    exp_d   = '0;
                    unf_d   = 1'b1;
                    state_d = S_DONE;
                end
            end

            S_DONE: begin
                if (out_ready) begin
                    ovf_d   = 1'b0;
                    unf_d   = 1'b0;
                    state_d = S_IDLE;
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and datapath registers; reset discards any operation in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            exp_q   <= '0;
            mant_q  <= '0;
            ovf_q   <= 1'b0;
            unf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            exp_q   <= exp_d;
            mant_q  <= mant_d;
            ovf_q   <= ovf_d;
            unf_q   <= unf_d;
        end
    end

    // Handshake and result outputs come straight from state and registers.
    always_comb begin
        in_ready                = (state_q == S_IDLE);
        out_valid               = (state_q == S_DONE);
        temp_floating_point_out = {1'b0, exp_q, mant_q[FRAC_W-1:0]};
        overflow                = ovf_q;
        underflow               = unf_q;
    end

endmodule

// File: tb/tb_fp_add_normalize.sv
// Scoreboard bench for fp_add_normalize: directed operands with hand-computed results.
// Stimulus pushes expected results; a negedge monitor pops on every output handshake.
// Latency, backpressure hold and mid-operation reset are checked inline.
module tb_fp_add_normalize;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [7:0]  in_exp;
    logic [24:0] in_mant;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] temp_floating_point_out;
    logic        overflow;
    logic        underflow;

    int checks   = 0;
    int failures = 0;

    logic [31:0] sb_dat[$];
    logic [1:0]  sb_flg[$];
    int          sb_id[$];

    fp_add_normalize #(.EXP_W(8), .FRAC_W(23)) dut (
        .clk                     (clk),
        .rst                     (rst),
        .in_valid                (in_valid),
        .in_ready                (in_ready),
        .in_exp                  (in_exp),
        .in_mant                 (in_mant),
        .out_valid               (out_valid),
        .out_ready               (out_ready),
        .temp_floating_point_out (temp_floating_point_out),
        .overflow                (overflow),
        .underflow               (underflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Monitor: an output handshake completes at the next rising edge.
    always @(negedge clk) begin
        logic [31:0] e_dat;
        logic [1:0]  e_flg;
        int          e_id;
        if (!rst && out_valid && out_ready) begin
            checks++;
            if (sb_dat.size() == 0) begin
                failures++;
                $display("FAIL spurious_output got=%h ovf=%b unf=%b expected=none",
                         temp_floating_point_out, overflow, underflow);
            end else begin
                e_dat = sb_dat.pop_front();
                e_flg = sb_flg.pop_front();
                e_id  = sb_id.pop_front();
                if (temp_floating_point_out !== e_dat || {overflow, underflow} !== e_flg) begin
                    failures++;
                    $display("FAIL result_%0d got=%h ovf=%b unf=%b expected=%h ovf=%b unf=%b",
                             e_id, temp_floating_point_out, overflow, underflow,
                             e_dat, e_flg[1], e_flg[0]);
                end
            end
        end
    end

    task automatic check_bit(input string name, input logic got, input logic want);
        checks++;
        if (got !== want) begin
            failures++;
            $display("FAIL %s got=%b expected=%b", name, got, want);
        end
    endtask

    // Issue one operand from IDLE (called at posedge+1), measure latency,
    // optionally stall the output for hold_cycles, then let it drain.
    task automatic run_op(input int id, input logic [7:0] e, input logic [24:0] m,
                          input logic [31:0] want_dat, input logic want_ovf,
                          input logic want_unf, input int want_lat, input int hold_cycles);
        int          lat;
        logic [31:0] held;
        sb_dat.push_back(want_dat);
        sb_flg.push_back({want_ovf, want_unf});
        sb_id.push_back(id);
        out_ready = (hold_cycles == 0);
        in_exp    = e;
        in_mant   = m;
        in_valid  = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        lat      = 1;
        while (!out_valid && lat < 40) begin
            @(posedge clk); #1;
            lat++;
        end
        checks++;
        if (!out_valid || lat != want_lat) begin
            failures++;
            $display("FAIL latency_%0d got=%0d valid=%b expected=%0d", id, lat, out_valid, want_lat);
        end
        if (hold_cycles > 0) begin
            held = temp_floating_point_out;
            // A competing operand offered while busy must be ignored.
            in_exp   = 8'd10;
            in_mant  = 25'h1000000;
            in_valid = 1'b1;
            for (int i = 0; i < hold_cycles; i++) begin
                @(posedge clk); #1;
                check_bit($sformatf("hold_valid_%0d_%0d", id, i), out_valid, 1'b1);
                check_bit($sformatf("hold_in_ready_%0d_%0d", id, i), in_ready, 1'b0);
                checks++;
                if (temp_floating_point_out !== held) begin
                    failures++;
                    $display("FAIL hold_data_%0d_%0d got=%h expected=%h",
                             id, i, temp_floating_point_out, held);
                end
            end
            in_valid  = 1'b0;
            out_ready = 1'b1;
        end
        @(posedge clk); #1;
        check_bit($sformatf("drain_in_ready_%0d", id), in_ready, 1'b1);
        check_bit($sformatf("drain_out_valid_%0d", id), out_valid, 1'b0);
    endtask

    initial begin
        int seen;
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_exp    = '0;
        in_mant   = '0;
        out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check_bit("reset_in_ready", in_ready, 1'b1);
        check_bit("reset_out_valid", out_valid, 1'b0);
        check_bit("reset_overflow", overflow, 1'b0);
        check_bit("reset_underflow", underflow, 1'b0);
        checks++;
        if (temp_floating_point_out !== 32'h0) begin
            failures++;
            $display("FAIL reset_out got=%h expected=00000000", temp_floating_point_out);
        end
        rst = 1'b0;
        @(posedge clk); #1;

        //     id  exp     mant          result        ovf   unf   lat hold
        run_op( 1, 8'd127, 25'h0800000, 32'h3F800000, 1'b0, 1'b0,  1, 0); // 1.0
        run_op( 2, 8'd127, 25'h1000000, 32'h40000000, 1'b0, 1'b0,  1, 0); // carry -> 2.0
        run_op( 3, 8'd254, 25'h1000000, 32'h7F800000, 1'b1, 1'b0,  1, 0); // carry overflow
        run_op( 4, 8'd130, 25'h0100000, 32'h3F800000, 1'b0, 1'b0,  5, 0); // 3 shifts
        run_op( 5, 8'd3,   25'h0000400, 32'h00001000, 1'b0, 1'b1,  4, 0); // denormal cutoff
        run_op( 6, 8'd100, 25'h0000000, 32'h00000000, 1'b0, 1'b0,  1, 0); // exact zero
        run_op( 7, 8'd255, 25'h0C00000, 32'h7FC00000, 1'b0, 1'b0,  1, 0); // NaN pass-through
        run_op( 8, 8'd127, 25'h1800001, 32'h40400000, 1'b0, 1'b0,  1, 0); // carry truncates LSB
        run_op( 9, 8'd254, 25'h1FFFFFF, 32'h7F800000, 1'b1, 1'b0,  1, 0); // fraction forced 0
        run_op(10, 8'd0,   25'h0400000, 32'h00400000, 1'b0, 1'b1,  2, 0); // exp 0 treated as 1
        run_op(11, 8'd127, 25'h0000001, 32'h34000000, 1'b0, 1'b0, 25, 0); // 23 shifts, worst case
        run_op(12, 8'd128, 25'h0C00000, 32'h40400000, 1'b0, 1'b0,  1, 4); // backpressure hold

        // Reset in the middle of a long shift sequence: nothing may come out.
        in_exp   = 8'd127;
        in_mant  = 25'h0000001;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_bit("shift_busy_in_ready", in_ready, 1'b0);
        rst = 1'b1;
        #1;
        check_bit("midrst_out_valid", out_valid, 1'b0);
        check_bit("midrst_in_ready", in_ready, 1'b1);
        checks++;
        if (temp_floating_point_out !== 32'h0) begin
            failures++;
            $display("FAIL midrst_out got=%h expected=00000000", temp_floating_point_out);
        end
        @(posedge clk); #1;
        rst  = 1'b0;
        seen = 0;
        for (int i = 0; i < 30; i++) begin
            @(posedge clk); #1;
            if (out_valid) seen++;
        end
        checks++;
        if (seen != 0) begin
            failures++;
            $display("FAIL post_reset_quiet got=%0d valid cycles expected=0", seen);
        end

        run_op(13, 8'd127, 25'h0800000, 32'h3F800000, 1'b0, 1'b0, 1, 0); // recovers after reset

        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (sb_dat.size() != 0) begin
            failures++;
            $display("FAIL scoreboard_drain got=%0d pending expected=0", sb_dat.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/fp_add_normalize.md
Name: fp_add_normalize

Overview:
- Multi-cycle normalization stage of the FPU add/sub datapath.
- Accepts the raw mantissa sum/difference and the provisional biased exponent from the mantissa adder.
- Normalizes iteratively, one left shift per cycle, or with a single carry right-shift.
- Emits the unsigned packed result on temp_floating_point_out[30:0]; the sign-determination stage consumes it directly and overwrites bit 31.
- Valid/ready handshakes on both sides.

Parameters:
- EXP_W, 8, exponent field width.
- FRAC_W, 23, fraction field width. The mantissa input is FRAC_W+2 bits: carry, hidden, fraction.

Ports:
- clk  input  1  clock, rising edge.
- rst  input  1  asynchronous reset, active-high.
- in_valid  input  1  upstream offers an operand.
- in_ready  output  1  block can accept; high only in IDLE.
- in_exp  input  EXP_W  provisional biased exponent (exponent of the larger operand).
- in_mant  input  FRAC_W+2  raw mantissa. Bit 24 is carry, bit 23 is hidden, bits 22:0 are fraction.
- out_valid  output  1  result available.
- out_ready  input  1  downstream accepts the result.
- temp_floating_point_out  output  32  {1'b0, exp, frac}.
- overflow  output  1  result saturated to infinity; valid with out_valid.
- underflow  output  1  result is denormal or zero from a non-zero input; valid with out_valid.

Behaviour:
- States: IDLE, SHIFT, DONE. Registers: state, exp_r (EXP_W), mant_r (FRAC_W+2), ovf_r, unf_r.
- Reset (async, immediate): state=IDLE, all data registers 0, in_ready=1, out_valid=0, temp_floating_point_out=0, overflow=0, underflow=0. Reset mid-operation discards the operation; no output is produced for it.
- IDLE, handshake in_valid & in_ready (capture cycle):
  - in_exp==255: copy operand to result, mant_r=in_mant; go DONE. NaN/inf pass-through, no flags.
  - in_mant==0: exp_r=0, mant_r=0; go DONE. Exact zero, underflow=0.
  - in_mant[24]==1: mant_r=in_mant>>1 (truncate), exp_r=in_exp+1.
    - If in_exp+1==255: mant_r fraction forced to 0 and ovf_r=1.
    - Go DONE.
  - in_mant[24:23]==01: mant_r=in_mant, exp_r=in_exp; go DONE.
  - Otherwise: mant_r=in_mant, exp_r=in_exp; go SHIFT. An in_exp of 0 is treated as 1.
- SHIFT, evaluated each cycle:
  - mant_r[23]==1: go DONE.
  - mant_r[23]==0 and exp_r>1: mant_r<<=1, exp_r-=1; stay in SHIFT.
  - mant_r[23]==0 and exp_r<=1: exp_r=0 (denormal encoding), unf_r=1; go DONE.
- DONE:
  - out_valid=1 and outputs are stable until out_ready.
  - On out_valid & out_ready: go IDLE and clear flags.
  - in_ready=0 in SHIFT and DONE; no overlap of operations.
- Output packing: temp_floating_point_out = {1'b0, exp_r, mant_r[22:0]}. Bit 31 is always 0.
- Latency, capture to out_valid:
  - 1 cycle for carry, already-normal, zero and special cases.
  - 1+k+1 cycles when k left shifts are needed; maximum k=23, giving a 25-cycle worst case.
  - The denormal cutoff terminates early.
- Rounding: truncation only. The bit shifted out on carry is dropped.
- out_ready held high in IDLE or SHIFT has no effect.
- in_valid held high while in_ready=0 is ignored; upstream must hold its data until in_ready.

Test Plan:
- in_exp=127, in_mant=25'h0800000 (1.0), out_ready=1 -> out_valid 1 cycle after capture, temp_floating_point_out=32'h3F800000, flags 0.
- in_exp=127, in_mant=25'h1000000 (carry) -> 32'h40000000 after 1 cycle. Then in_exp=254 with carry -> 32'h7F800000, overflow=1.
- in_exp=130, in_mant=25'h0100000 (3 leading zeros) -> SHIFT for 3 shifts, out_valid 5 cycles after capture, result 32'h3F800000 with exp 127.
- in_exp=3, in_mant=25'h0000400 -> shifting stops at exp 1, exp field 0, fraction 23'h001000, underflow=1.
- in_mant=0 with any exp<255 -> 32'h00000000, underflow=0. in_exp=255, in_mant=25'h0C00000 -> 32'h7FC00000 passes through.
- Backpressure and reset:
  - out_ready=0 for 4 cycles in DONE -> output held constant, in_ready=0.
  - Asserting rst during SHIFT -> out_valid=0 and in_ready=1 immediately, with no spurious result after release.
